// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, ALU codes,
// datapath mux selects and opcodes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to the ALU operation code.
module aludec
    import mc_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic [6:0]  i_op,
    output logic [3:0]  o_alucontrol
);

    logic w_rtype_sub;

    assign w_rtype_sub = (i_op == OP_R) && i_funct7b5;

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alucontrol = w_rtype_sub ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alucontrol = ALU_SLL;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b100:  o_alucontrol = ALU_XOR;
                    3'b101:  o_alucontrol = ALU_SRL;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore sequencing FSM, ImmSrc decode and
// branch resolution driving every datapath select and write enable.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        RegWrite,
    output logic        InstrDone
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcupdate;
    logic   w_branch;
    logic   w_memwrite;
    logic   w_irwrite;
    logic   w_regwrite;
    logic   w_done;
    logic   w_taken;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next state and per-state datapath controls
    always_comb begin
        w_next     = S_FETCH;
        w_aluop    = ALUOP_ADD;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_done     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        case (r_state)
            S_FETCH: begin
                w_irwrite  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                w_pcupdate = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BR:        w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next = S_FETCH;
                        w_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_A;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_A;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // ImmSrc depends on the opcode alone, independent of state
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BR:   ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    assign w_taken = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);

    // Architectural write enables are suppressed while reset is held
    assign PCWrite   = (w_pcupdate | (w_branch & w_taken)) & ~reset;
    assign MemWrite  = w_memwrite & ~reset;
    assign IRWrite   = w_irwrite & ~reset;
    assign RegWrite  = w_regwrite & ~reset;
    assign InstrDone = w_done & ~reset;

    aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct3     (funct3),
        .i_funct7b5   (funct7b5),
        .i_op         (op),
        .o_alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against an
// instruction-level model of the control step sequence.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BR, P_J} phase_t;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite,InstrDone}
    localparam logic [17:0] WMASK = 18'b1_0_1_1_00_00_00_00_0000_1_1;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .InstrDone  (InstrDone)
    );

    wire [17:0] w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                         ALUSrcB, ImmSrc, ALUControl, RegWrite, InstrDone};

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return 4'd7;
            3'd6:    return 4'd3;
            3'd7:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Expected control word for one step of an instruction
    function automatic logic [17:0] exp_vec(input phase_t p, input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic last);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [3:0] alu = 0;
        case (p)
            P_F:   begin irw = 1; sb = 2; rs = 2; pcw = 1; end
            P_D:   begin sa = 1; sb = 1; end
            P_MA:  begin sa = 2; sb = 1; end
            P_MR:  adr = 1;
            P_MWB: begin rs = 1; rw = 1; end
            P_MW:  begin adr = 1; mw = 1; end
            P_ER:  begin sa = 2; alu = funct_alu(o, f3, f7); end
            P_EI:  begin sa = 2; sb = 1; alu = funct_alu(o, f3, f7); end
            P_AWB: rw = 1;
            P_BR:  begin sa = 2; alu = 4'd1; pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
            P_J:   begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, imm_of(o), alu, rw, last};
    endfunction

    // Runs one instruction from its FETCH cycle; optionally asserts reset at step rst_at.
    // On entry and exit the bench sits 1 time unit after a rising edge.
    task automatic run_instr(input logic [31:0] instr, input int zforce, input int rst_at, input string name);
        phase_t seq[$];
        logic [6:0] o = instr[6:0];
        case (o)
            7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
            7'b0100011: seq = '{P_F, P_D, P_MA, P_MW};
            7'b0110011: seq = '{P_F, P_D, P_ER, P_AWB};
            7'b0010011: seq = '{P_F, P_D, P_EI, P_AWB};
            7'b1100011: seq = '{P_F, P_D, P_BR};
            7'b1101111: seq = '{P_F, P_D, P_J, P_AWB};
            default:    seq = '{P_F, P_D};
        endcase
        for (int k = 0; k < seq.size(); k++) begin
            logic [17:0] e;
            op       = o;
            funct3   = instr[14:12];
            funct7b5 = instr[30];
            Zero     = (zforce < 0) ? 1'($urandom_range(0, 1)) : 1'(zforce);
            if (k == rst_at) reset = 1'b1;
            @(negedge clk);
            e = exp_vec(seq[k], o, funct3, funct7b5, Zero, k == seq.size() - 1);
            if (k == rst_at) e = e & ~WMASK;
            check_eq($sformatf("%s step%0d", name, k), w_obs, e);
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] o;
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 6))
            0: begin o = 7'b0000011; f3 = 3'd2; end
            1: begin o = 7'b0100011; f3 = 3'd2; end
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: begin o = 7'b1100011; f3 = 3'($urandom_range(0, 1)); end
            5: o = 7'b1101111;
            default: begin
                do o = 7'($urandom_range(0, 127));
                while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                       o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
            end
        endcase
        return {1'b0, 1'($urandom_range(0, 1)), 15'($urandom), f3, 5'($urandom), o};
    endfunction

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq($sformatf("reset_writes%0d", i), w_obs & WMASK, 18'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(32'h00402283, -1, -1, "lw");
        run_instr(32'h402081B3, -1, -1, "sub");
        run_instr(32'h002081B3, -1, -1, "add");
        run_instr(32'h00208063, 1, -1, "beq_z1");
        run_instr(32'h00208063, 0, -1, "beq_z0");
        run_instr(32'h00209063, 1, -1, "bne_z1");
        run_instr(32'h00209063, 0, -1, "bne_z0");
        run_instr(32'h008000EF, -1, -1, "jal");
        run_instr(32'h0000007F, -1, -1, "illegal");
        run_instr(32'h00402283, -1, 3, "lw_rst_memread");
        run_instr(32'h00112223, -1, 3, "sw_rst_memwrite");
        run_instr(32'h00402283, -1, -1, "lw_after_rst");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins = rand_instr();
            int ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, -1, ra, $sformatf("rnd%0d_%h", i, ins));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core: a Moore FSM plus ALU decoder that sequences a shared-memory, single-ALU multicycle datapath through fetch, decode, execute, memory and writeback steps. It sits beside the datapath and drives every mux select and write enable. Its inputs are the latched instruction fields and the ALU `Zero` flag. It replaces the purely combinational single-cycle control path wherever the core runs in multicycle mode.

## Interface
- No parameters. Encodings come from `mc_pkg`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 7: `Instr[6:0]`.
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction and OldPC register enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = A register.
- `ALUSrcB` out 2: ALU B select. 00 = WriteData, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate type. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 4: ALU operation code.
- `RegWrite` out 1: register file write enable.
- `InstrDone` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=ADD, ResultSrc=10, PCUpdate=1. Always goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=ADD (branch target).
  - op 0000011 or 0100011 → MEMADR.
  - op 0110011 → EXECUTER.
  - op 0010011 → EXECUTEI.
  - op 1100011 → BRANCH.
  - op 1101111 → JAL.
  - Any other op → FETCH. No write enables asserted; InstrDone=1, so an illegal instruction is skipped.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=ADD. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Goes to FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, InstrDone=1. Goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=FUNCT. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=FUNCT. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=SUB, ResultSrc=00, Branch=1, InstrDone=1. Goes to FETCH.
  - Taken when funct3=000 and Zero=1, or funct3=001 and Zero=0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=ADD, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- PCWrite = PCUpdate | (Branch & taken).
- ImmSrc is decoded from op alone: lw/I-type 00, sw 01, beq/bne 10, jal 11. Unknown op gives 00.
- ALU decoder, applied when ALUOp=FUNCT:
  - funct3 000: SUB only when op=0110011 and funct7b5=1; otherwise ADD.
  - 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 011 defaults to ADD.
- `ALUControl` codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111.
- All outputs not listed for a state are 0.

## Timing
- State register updates on the rising `clk` edge. All outputs are combinational from state and inputs; only PCWrite depends on `Zero`.
- While `reset`=1: PCWrite, MemWrite, IRWrite, RegWrite and InstrDone are forced to 0. The next edge loads FETCH.
- After reset releases, the first cycle is FETCH with FETCH outputs. This defines the reset value of every output.
- Reset asserted mid-instruction: the instruction is abandoned with no further architectural writes, and FETCH follows on the next edge.
- Latency in cycles, FETCH through the InstrDone cycle inclusive:
  - lw 5; sw 4; R-type 4; I-type ALU 4; jal 4; beq/bne 3; illegal 2.
- InstrDone is high for exactly one cycle per instruction. The cycle after InstrDone is always FETCH.

## Structure
- `mc_pkg` holds the state enum, the ALUControl code constants, ImmSrc/ResultSrc/ALUSrcA/ALUSrcB codes, the opcode constants and the internal ALUOp enum {ADD, SUB, FUNCT}.
- One sub-module, `aludec`: combinational, mapping ALUOp/funct3/funct7b5/op to ALUControl.
- FSM, output decode and ImmSrc decode live in `mc_controller`.

## Test plan
- Reset held 2 cycles, then released → first cycle FETCH, IRWrite=1, PCWrite=1, ALUSrcB=10; all writes stayed 0 while `reset`=1.
- lw x5,4(x0) (0x00402283) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, with ResultSrc=01.
- sub x3,x1,x2 (0x402081B3) → EXECUTER shows ALUControl=0001; add (0x002081B3) shows 0000; 4 cycles, InstrDone in cycle 4.
- beq with Zero=1 → PCWrite=1 in BRANCH. Zero=0 → PCWrite=0. bne (funct3=001) gives the inverse. Both take 3 cycles.
- jal (op 1101111) → ImmSrc=11; JAL state asserts PCWrite with ALUSrcA=01, ALUSrcB=10; ALUWB writes rd; 4 cycles.
- Illegal op 0x0000007F, plus reset asserted during MEMREAD of a lw → no RegWrite or MemWrite; the illegal op returns to FETCH after DECODE, and the reset case lands in FETCH on the next edge.
